// File: rtl/sudoku_pkg.sv
// Shared types and constants for the serial sudoku board checker.
// cell_index maps (group, position-in-group) to a row-major cell number.
package sudoku_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         NUM_CELLS  = 81;
  localparam int         NUM_GROUPS = 27;
  localparam logic [4:0] ROW_BASE   = 5'd0;
  localparam logic [4:0] COL_BASE   = 5'd9;
  localparam logic [4:0] BOX_BASE   = 5'd18;
  localparam logic [4:0] FAIL_NONE  = 5'd31;

  // Groups 27..31 never occur in CHECK; they harmlessly map to cell 0.
  function automatic logic [6:0] cell_index(input logic [4:0] grp, input logic [3:0] k);
    logic [4:0] box;
    logic [6:0] row;
    logic [6:0] col;
    box = '0;
    row = '0;
    col = '0;
    if (grp < COL_BASE) begin
      row = 7'(grp - ROW_BASE);
      col = 7'(k);
    end else if (grp < BOX_BASE) begin
      row = 7'(k);
      col = 7'(grp - COL_BASE);
    end else if (grp < 5'(NUM_GROUPS)) begin
      box = grp - BOX_BASE;
      row = 7'(box / 5'd3) * 7'd3 + 7'(k / 4'd3);
      col = 7'(box % 5'd3) * 7'd3 + 7'(k % 4'd3);
    end
    return row * 7'd9 + col;
  endfunction

endpackage

// File: rtl/legalBoard.sv
// Nine-digit group checker: legal when the digits are exactly 1..9 once each.
module legalBoard (
  input  logic [3:0] digits [9],
  output logic       legal
);

  logic [15:0] seen;

  // Out-of-range values (0, 10-15) and repeats both make the group illegal.
  always_comb begin
    seen  = '0;
    legal = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (digits[k] == 4'd0 || digits[k] > 4'd9 || seen[digits[k]]) legal = 1'b0;
      seen[digits[k]] = 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_group_mux.sv
// Routes the 9 cells of row/column/box group 'group' out in group order.
module sudoku_group_mux
  import sudoku_pkg::*;
(
  input  logic [3:0] cells [NUM_CELLS],
  input  logic [4:0] group,
  output logic [3:0] digits [9]
);

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      digits[k] = cells[cell_index(group, 4'(k))];
    end
  end

endmodule

// File: rtl/sudoku_checker.sv
// Serial 81-digit board loader that checks all 27 groups through one shared
// legalBoard, one group per cycle, reporting legality and the first failing group.
module sudoku_checker
  import sudoku_pkg::*;
#(
  parameter logic STOP_ON_FAIL = 1'b1
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       busy,
  output logic       done,
  output logic       legal,
  output logic [4:0] fail_group
);

  state_t     state;
  logic [6:0] count;
  logic [4:0] group;
  logic       failed;
  logic [3:0] cells [NUM_CELLS];
  logic [3:0] group_digits [9];
  logic       group_ok;
  logic       group_fail;

  assign digit_ready = (state == LOAD);
  assign busy        = (state == LOAD) || (state == CHECK);
  assign group_fail  = !group_ok;

  // Board storage carries no reset; every load rewrites all 81 cells.
  always_ff @(posedge clock) begin
    if (state == LOAD && digit_valid) cells[count] <= digit_in;
  end

  sudoku_group_mux u_mux (
    .cells  (cells),
    .group  (group),
    .digits (group_digits)
  );

  legalBoard u_legal (
    .digits (group_digits),
    .legal  (group_ok)
  );

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state      <= IDLE;
      count      <= '0;
      group      <= '0;
      failed     <= 1'b0;
      done       <= 1'b0;
      legal      <= 1'b0;
      fail_group <= FAIL_NONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            count      <= '0;
            failed     <= 1'b0;
            done       <= 1'b0;
            legal      <= 1'b0;
            fail_group <= FAIL_NONE;
          end
        end
        LOAD: begin
          if (digit_valid) begin
            if (count == 7'(NUM_CELLS - 1)) begin
              state <= CHECK;
              group <= '0;
            end else begin
              count <= count + 7'd1;
            end
          end
        end
        CHECK: begin
          // Only the first failing group is remembered, even when scanning on.
          if (group_fail && !failed) begin
            fail_group <= group;
            failed     <= 1'b1;
          end
          if ((group_fail && STOP_ON_FAIL) || group == 5'(NUM_GROUPS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            legal <= !(failed || group_fail);
          end else begin
            group <= group + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_checker.sv
// Randomized/directed bench for sudoku_checker; two instances (stop-on-fail
// and full-scan) share one input stream and are checked against a set model.
module tb_sudoku_checker;

  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic       start = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit_in = 4'd0;

  logic       ready1, busy1, done1, legal1;
  logic [4:0] fg1;
  logic       ready0, busy0, done0, legal0;
  logic [4:0] fg0;

  int tests = 0;
  int fails = 0;
  int board [81];

  always #5 clock = ~clock;

  sudoku_checker #(.STOP_ON_FAIL(1'b1)) dut_stop (
    .clock       (clock),
    .reset_N     (reset_N),
    .start       (start),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (ready1),
    .busy        (busy1),
    .done        (done1),
    .legal       (legal1),
    .fail_group  (fg1)
  );

  sudoku_checker #(.STOP_ON_FAIL(1'b0)) dut_scan (
    .clock       (clock),
    .reset_N     (reset_N),
    .start       (start),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (ready0),
    .busy        (busy0),
    .done        (done0),
    .legal       (legal0),
    .fail_group  (fg0)
  );

  // Reference: a group passes when its histogram holds each of 1..9 exactly once.
  function automatic int ref_first_fail();
    for (int g = 0; g < 27; g++) begin
      int hist [16];
      bit ok;
      for (int v = 0; v < 16; v++) hist[v] = 0;
      for (int k = 0; k < 9; k++) begin
        int idx;
        int b;
        if (g < 9) idx = g * 9 + k;
        else if (g < 18) idx = k * 9 + (g - 9);
        else begin
          b   = g - 18;
          idx = (3 * (b / 3) + k / 3) * 9 + 3 * (b % 3) + k % 3;
        end
        hist[board[idx]]++;
      end
      ok = 1'b1;
      for (int v = 1; v <= 9; v++) if (hist[v] != 1) ok = 1'b0;
      if (!ok) return g;
    end
    return 31;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_relabeled();
    int p [9];
    int j, t;
    for (int i = 0; i < 9; i++) p[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = p[(3 * r + r / 3 + c) % 9];
  endtask

  task automatic fill_canonical();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = ((3 * r + r / 3 + c) % 9) + 1;
  endtask

  task automatic start_load(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, "_ready"}, 32'(ready1), 1);
    check_output({tag, "_busy"}, 32'(busy1), 1);
    check_output({tag, "_done_clr"}, 32'(done1), 0);
    check_output({tag, "_fg_clr"}, 32'(fg1), 31);
  endtask

  // gap_mode 0: back-to-back, 1: every other cycle plus a 5-cycle gap, 2: random gaps.
  task automatic apply_stimulus(input int gap_mode, input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      int idle;
      idle = 0;
      if (gap_mode == 1) idle = (i == 40) ? 5 : ((i > 0) ? 1 : 0);
      else if (gap_mode == 2) idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) step();
      digit_valid = 1'b1;
      digit_in    = 4'(board[i]);
      start       = (i == pulse_at);
      step();
      digit_valid = 1'b0;
      start       = 1'b0;
    end
  endtask

  // Called right after the edge that accepted the 81st digit (cycle A+1).
  task automatic expect_result(input string tag);
    int exp_fg;
    int d1;
    exp_fg = ref_first_fail();
    d1     = (exp_fg == 31) ? 27 : exp_fg + 1;
    check_output({tag, "_ready_low"}, 32'(ready1), 0);
    for (int k = 0; k <= 27; k++) begin
      if (k > 0) step();
      if (k == d1 - 1) check_output({tag, "_stop_done_early"}, 32'(done1), 0);
      if (k == d1) begin
        check_output({tag, "_stop_done"}, 32'(done1), 1);
        check_output({tag, "_stop_busy"}, 32'(busy1), 0);
        check_output({tag, "_stop_legal"}, 32'(legal1), (exp_fg == 31) ? 1 : 0);
        check_output({tag, "_stop_fg"}, 32'(fg1), 32'(exp_fg));
      end
      if (k == 26) check_output({tag, "_scan_done_early"}, 32'(done0), 0);
      if (k == 27) begin
        check_output({tag, "_scan_done"}, 32'(done0), 1);
        check_output({tag, "_scan_busy"}, 32'(busy0), 0);
        check_output({tag, "_scan_legal"}, 32'(legal0), (exp_fg == 31) ? 1 : 0);
        check_output({tag, "_scan_fg"}, 32'(fg0), 32'(exp_fg));
      end
    end
  endtask

  initial begin
    reset_N = 1'b0;
    step();
    step();
    reset_N = 1'b1;
    check_output("rst_ready", 32'(ready1), 0);
    check_output("rst_busy", 32'(busy1), 0);
    check_output("rst_done", 32'(done1), 0);
    check_output("rst_legal", 32'(legal1), 0);
    check_output("rst_fg", 32'(fg1), 31);
    check_output("rst_scan_fg", 32'(fg0), 31);

    fill_canonical();
    start_load("canon");
    apply_stimulus(0, 81, -1);
    expect_result("canon");

    fill_canonical();
    begin
      int t;
      t = board[0]; board[0] = board[1]; board[1] = t;
    end
    start_load("swap01");
    apply_stimulus(0, 81, -1);
    expect_result("swap01");

    fill_canonical();
    board[80] = 0;
    start_load("cell80zero");
    apply_stimulus(0, 81, -1);
    expect_result("cell80zero");

    fill_relabeled();
    start_load("gapped");
    apply_stimulus(1, 81, -1);
    expect_result("gapped");

    for (int i = 0; i < 81; i++) board[i] = 0;
    start_load("partial");
    apply_stimulus(0, 40, -1);
    reset_N = 1'b0;
    step();
    reset_N = 1'b1;
    check_output("midrst_busy", 32'(busy1), 0);
    check_output("midrst_ready", 32'(ready1), 0);
    check_output("midrst_done", 32'(done1), 0);
    fill_relabeled();
    start_load("reload");
    apply_stimulus(0, 81, 20);
    expect_result("reload");

    fill_relabeled();
    start = 1'b1;
    digit_valid = 1'b1;
    digit_in = 4'd0;
    step();
    start = 1'b0;
    digit_valid = 1'b0;
    check_output("restart_done", 32'(done1), 0);
    check_output("restart_fg", 32'(fg1), 31);
    check_output("restart_ready", 32'(ready1), 1);
    apply_stimulus(0, 81, -1);
    expect_result("restart");

    for (int t = 0; t < 6; t++) begin
      int n;
      fill_relabeled();
      n = $urandom_range(0, 2);
      for (int e = 0; e < n; e++) board[$urandom_range(0, 80)] = int'($urandom_range(0, 15));
      start_load("rand");
      apply_stimulus(2, 81, -1);
      expect_result("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
